// File: rtl/dmux_8way.sv
// dmux_8way: registered 1-to-8 demultiplexer for the Hack datapath
// Routes `in` to the output chosen by `sel` (0->a ... 7->h) and zeroes the other seven.
// The outputs are registered, so there is one cycle of latency and no path from in/sel to a..h.
// Ports: clk, rst_n (async active-low), in[WIDTH], sel[3], a..h[WIDTH],
//        en (present only when DMUX_8WAY_HOLD_EN is defined; en=0 holds all outputs)
module dmux_8way #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef DMUX_8WAY_HOLD_EN
  input  logic             en,
`endif
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h
);
  logic [WIDTH-1:0] q [8];
  logic             upd;
`ifdef DMUX_8WAY_HOLD_EN
  assign upd = en;
`else
  assign upd = 1'b1;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < 8; i++) q[i] <= '0;
    else if (upd)
      for (int i = 0; i < 8; i++) q[i] <= (sel == 3'(i)) ? in : '0;
  assign {a, b, c, d} = {q[0], q[1], q[2], q[3]};
  assign {e, f, g, h} = {q[4], q[5], q[6], q[7]};
endmodule

// File: tb/tb_dmux_8way.sv
module tb_dmux_8way;
  logic        clk = 0;
  logic        rst_n = 1;
  logic        en = 1;
  logic [2:0]  sel = 3;
  logic [15:0] in16 = 16'h0001;
  logic        in1 = 1;
  logic [15:0] a16, b16, c16, d16, e16, f16, g16, h16;
  logic        a1, b1, c1, d1, e1, f1, g1, h1;
  int vectors = 0, miscompares = 0;
  typedef struct packed {logic [127:0] w16; logic [7:0] w1;} exp_t;
  exp_t sb[$];
  exp_t prev = '0;
  always #5 clk = ~clk;
  dmux_8way #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n),
`ifdef DMUX_8WAY_HOLD_EN
    .en(en),
`endif
    .in(in16), .sel(sel),
    .a(a16), .b(b16), .c(c16), .d(d16), .e(e16), .f(f16), .g(g16), .h(h16)
  );
  dmux_8way #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n),
`ifdef DMUX_8WAY_HOLD_EN
    .en(en),
`endif
    .in(in1), .sel(sel),
    .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1), .h(h1)
  );
  function automatic exp_t actual();
    return '{w16: {h16, g16, f16, e16, d16, c16, b16, a16}, w1: {h1, g1, f1, e1, d1, c1, b1, a1}};
  endfunction
  task automatic chk(input string name, input exp_t act, input exp_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got w16=%h w1=%b, want w16=%h w1=%b", name, act.w16, act.w1, exp.w16, exp.w1);
    end
  endtask
  // Reference: the selected lane carries the data, every other lane is zero; en=0 keeps last result.
  task automatic step(input logic [15:0] din, input logic [2:0] s, input logic enable);
    exp_t x;
    logic hold;
    @(negedge clk);
    in16 = din; in1 = din[0]; sel = s; en = enable;
`ifdef DMUX_8WAY_HOLD_EN
    hold = !enable;
`else
    hold = 1'b0;
`endif
    if (hold) x = prev;
    else begin
      x.w16 = 128'(din) << (32'(s) * 16);
      x.w1 = 8'(din[0]) << s;
    end
    prev = x;
    sb.push_back(x);
  endtask
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) chk("routed", actual(), sb.pop_front());
  end
  initial begin
    #1 rst_n = 0;
    #1 chk("async_reset", actual(), '0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int s = 0; s < 8; s++) step(16'h0001, 3'(s), 1'b1);
    step(16'h0000, 3'd0, 1'b1);
    step(16'h0001, 3'd2, 1'b1);
    step(16'h0001, 3'd5, 1'b1);
    #1 chk("no_comb_path", actual(), '{w16: 128'h1 << 32, w1: 8'b0000_0100});
    step(16'hA5C3, 3'd6, 1'b1);
    step(16'h0001, 3'd1, 1'b1);
    step(16'h0001, 3'd4, 1'b0);
    step(16'h0001, 3'd4, 1'b1);
    for (int i = 0; i < 200; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      if ($urandom_range(0, 7) == 0) d = '0;
      step(d, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0));
      if (i == 100) begin
        @(posedge clk); #2;
        rst_n = 0; in16 = '0; in1 = 0;
        #1 chk("mid_reset", actual(), '0);
        prev = '0;
        @(negedge clk);
        rst_n = 1;
      end
    end
    for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
